clock_div_ctrl: RTL and testbench

//  Controller for the rollover-counter / derived-clock datapath. Owns the divide counter, the
//  o_roll_over tick and the derived clock o_clk, and sequences them:
//  - start/stop with a clean park level
//  - run-time reprogramming of the divide ratio through a valid/ready handshake
//  - ratio changes take effect only on a rollover boundary, so o_clk never glitches

---
 rtl/clock_div_ctrl_pkg.sv | 14 +
 rtl/clock_div_ctrl_rollover_counter.sv | 31 +++
 rtl/clock_div_ctrl.sv | 103 ++++++++++
 tb/tb_clock_div_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_div_ctrl_pkg.sv
// Shared types and default sizing for the derived-clock controller.
package clock_div_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      PENDING  = 2'd2,
      STOPPING = 2'd3
   } div_state_t;

   localparam int DIV_WIDTH   = 8;
   localparam int DIV_DEFAULT = 4;

endpackage

// File: rtl/clock_div_ctrl_rollover_counter.sv
// Divide counter: counts 0..limit while running and is held at 0 otherwise.
module rollover_counter
   import clock_div_ctrl_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_run,
   input  logic [WIDTH-1:0] i_limit,
   output logic [WIDTH-1:0] o_count,
   output logic             o_roll_over
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         count <= '0;
      end else if (!i_run || (count == i_limit)) begin
         count <= '0;
      end else begin
         count <= count + WIDTH'(1);
      end
   end

   // i_run comes from the controller's state register, so the tick is register-decoded.
   assign o_roll_over = i_run && (count == i_limit);
   assign o_count     = count;

endmodule

// File: rtl/clock_div_ctrl.sv
// Sequences the divide counter and derived clock: start/stop with a park level of 1
// and glitch-free ratio changes that only land on a rollover boundary.
module clock_div_ctrl
   import clock_div_ctrl_pkg::*;
#(
   parameter int WIDTH       = DIV_WIDTH,
   parameter int DEFAULT_DIV = DIV_DEFAULT
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_enable,
   input  logic             i_div_valid,
   input  logic [WIDTH-1:0] i_div_value,
   output logic             o_div_ready,
   output logic             o_roll_over,
   output logic             o_clk,
   output logic             o_running,
   output logic [WIDTH-1:0] o_count
);

   // Handshake: a limit transfers on a rising edge where i_div_valid && o_div_ready;
   // an offer seen while o_div_ready is low is simply re-evaluated on later cycles.

   div_state_t       state, state_next;
   logic [WIDTH-1:0] limit;
   logic [WIDTH-1:0] pending;
   logic             clk_q;
   logic             accept;
   logic             roll;
   logic             run;

   assign accept = i_div_valid && o_div_ready;
   assign run    = (state != IDLE);

   rollover_counter #(.WIDTH(WIDTH)) u_counter (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_run       (run),
      .i_limit     (limit),
      .o_count     (o_count),
      .o_roll_over (roll)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (i_enable) state_next = RUN;
         end
         RUN: begin
            // A same-edge offer wins; a stop request is then honoured from PENDING.
            if (accept)         state_next = PENDING;
            else if (!i_enable) state_next = STOPPING;
         end
         PENDING: begin
            if (roll) state_next = i_enable ? RUN : STOPPING;
         end
         STOPPING: begin
            // Only the rollover that brings o_clk back to 1 may park the clock.
            if (i_enable)             state_next = RUN;
            else if (roll && !clk_q)  state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      o_div_ready = 1'b0;
      o_running   = 1'b0;
      case (state)
         IDLE:     o_div_ready = 1'b1;
         RUN:      begin o_div_ready = 1'b1; o_running = 1'b1; end
         PENDING:  o_running = 1'b1;
         STOPPING: o_running = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         limit   <= WIDTH'(DEFAULT_DIV);
         pending <= '0;
         clk_q   <= 1'b1;
      end else begin
         if (accept && (state == IDLE)) limit <= i_div_value;
         if (accept && (state == RUN))  pending <= i_div_value;
         if ((state == PENDING) && roll) limit <= pending;
         if (roll) clk_q <= ~clk_q;
      end
   end

   assign o_roll_over = roll;
   assign o_clk       = clk_q;

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Directed bench for clock_div_ctrl: expected rollover ticks are queued by the stimulus
// and matched by a monitor against {cycle, o_clk, o_count}.
module tb_clock_div_ctrl;
   import clock_div_ctrl_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         en  = 1'b0;
   logic         dv  = 1'b0;
   logic [W-1:0] dval = '0;
   logic         div_ready, roll_over, dclk, running;
   logic [W-1:0] count;

   int  cyc = 0;
   int  n_checks = 0;
   int  n_errors = 0;
   bit  mon_en = 1'b0;
   int  e;
   logic [32:0] exp_q[$];

   clock_div_ctrl #(.WIDTH(W), .DEFAULT_DIV(4)) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_enable    (en),
      .i_div_valid (dv),
      .i_div_value (dval),
      .o_div_ready (div_ready),
      .o_roll_over (roll_over),
      .o_clk       (dclk),
      .o_running   (running),
      .o_count     (count)
   );

   // clock / cycle index: cycle n is the interval after rising edge n
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_tick(input int c, input logic lvl, input int cnt);
      exp_q.push_back({c[23:0], lvl, cnt[7:0]});
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // called at a falling edge; returns the rising edge that samples enable
   task automatic start_run(output int edge_no);
      en = 1'b1;
      edge_no = cyc + 1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en  = 1'b0;
      dv  = 1'b0;
      #1;
      chk("rst_clk", 32'(dclk), 32'd1);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_ready", 32'(div_ready), 32'd1);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_roll", 32'(roll_over), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      chk("drain", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   // monitor
   always @(posedge clk) begin
      logic [32:0] exp_v, act_v;
      #1;
      if (mon_en && roll_over === 1'b1) begin
         act_v = {cyc[23:0], dclk, count};
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL tick_unexpected: got cycle %0d clk %0d count %0d, expected no tick",
                     act_v[32:9], act_v[8], act_v[7:0]);
         end else begin
            exp_v = exp_q.pop_front();
            if (act_v !== exp_v) begin
               n_errors++;
               $display("FAIL tick: got cycle %0d clk %0d count %0d expected cycle %0d clk %0d count %0d",
                        act_v[32:9], act_v[8], act_v[7:0], exp_v[32:9], exp_v[8], exp_v[7:0]);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      @(negedge clk);
      do_reset();
      mon_en = 1'b1;

      // 1: limit 4 from reset
      start_run(e);
      push_tick(e + 4, 1'b1, 4);
      push_tick(e + 9, 1'b0, 4);
      push_tick(e + 14, 1'b1, 4);
      wait_cyc(e + 14);
      do_reset();

      // 2: reprogram to 1 while running
      start_run(e);
      push_tick(e + 4, 1'b1, 4);
      push_tick(e + 9, 1'b0, 4);
      push_tick(e + 11, 1'b1, 1);
      push_tick(e + 13, 1'b0, 1);
      push_tick(e + 15, 1'b1, 1);
      push_tick(e + 17, 1'b0, 1);
      wait_cyc(e + 6);
      dv = 1'b1;
      dval = 8'd1;
      wait_cyc(e + 7);
      dv = 1'b0;
      chk("pend_ready", 32'(div_ready), 32'd0);
      wait_cyc(e + 10);
      chk("pend_done_ready", 32'(div_ready), 32'd1);
      wait_cyc(e + 17);
      do_reset();

      // 3: limit 0 loaded in IDLE
      chk("idle_ready", 32'(div_ready), 32'd1);
      dv = 1'b1;
      dval = 8'd0;
      @(negedge clk);
      dv = 1'b0;
      chk("idle_running", 32'(running), 32'd0);
      start_run(e);
      push_tick(e, 1'b1, 0);
      push_tick(e + 1, 1'b0, 0);
      push_tick(e + 2, 1'b1, 0);
      push_tick(e + 3, 1'b0, 0);
      wait_cyc(e + 3);
      do_reset();

      // 4a: stop while o_clk is low
      start_run(e);
      push_tick(e + 4, 1'b1, 4);
      push_tick(e + 9, 1'b0, 4);
      wait_cyc(e + 6);
      en = 1'b0;
      wait_cyc(e + 8);
      chk("stop_ready", 32'(div_ready), 32'd0);
      wait_cyc(e + 10);
      chk("stopa_running", 32'(running), 32'd0);
      chk("stopa_clk", 32'(dclk), 32'd1);
      chk("stopa_count", 32'(count), 32'd0);
      wait_cyc(e + 16);
      do_reset();

      // 4b: stop while o_clk is high -> one extra low phase
      start_run(e);
      push_tick(e + 4, 1'b1, 4);
      push_tick(e + 9, 1'b0, 4);
      wait_cyc(e + 2);
      en = 1'b0;
      wait_cyc(e + 7);
      chk("stopb_mid_running", 32'(running), 32'd1);
      chk("stopb_mid_clk", 32'(dclk), 32'd0);
      wait_cyc(e + 11);
      chk("stopb_running", 32'(running), 32'd0);
      chk("stopb_clk", 32'(dclk), 32'd1);
      chk("stopb_count", 32'(count), 32'd0);
      wait_cyc(e + 16);
      do_reset();

      // 4c: re-enable while stopping keeps phase
      start_run(e);
      push_tick(e + 4, 1'b1, 4);
      push_tick(e + 9, 1'b0, 4);
      push_tick(e + 14, 1'b1, 4);
      wait_cyc(e + 2);
      en = 1'b0;
      wait_cyc(e + 3);
      chk("restart_running", 32'(running), 32'd1);
      en = 1'b1;
      wait_cyc(e + 14);
      do_reset();

      // 5: async reset mid-run drops the pending limit
      start_run(e);
      push_tick(e + 4, 1'b1, 4);
      wait_cyc(e + 6);
      dv = 1'b1;
      dval = 8'd2;
      wait_cyc(e + 7);
      dv = 1'b0;
      wait_cyc(e + 8);
      #2 rst = 1'b1;
      #1;
      chk("async_clk", 32'(dclk), 32'd1);
      chk("async_running", 32'(running), 32'd0);
      chk("async_count", 32'(count), 32'd0);
      chk("async_ready", 32'(div_ready), 32'd1);
      en = 1'b0;
      #1 rst = 1'b0;
      @(negedge clk);
      start_run(e);
      push_tick(e + 4, 1'b1, 4);
      push_tick(e + 9, 1'b0, 4);
      wait_cyc(e + 9);
      do_reset();

      // 6: offer 2 and disable on the same edge
      start_run(e);
      push_tick(e + 4, 1'b1, 4);
      push_tick(e + 9, 1'b0, 4);
      push_tick(e + 12, 1'b1, 2);
      push_tick(e + 15, 1'b0, 2);
      wait_cyc(e + 6);
      dv = 1'b1;
      dval = 8'd2;
      en = 1'b0;
      wait_cyc(e + 7);
      dv = 1'b0;
      wait_cyc(e + 8);
      chk("same_pend_running", 32'(running), 32'd1);
      chk("same_pend_ready", 32'(div_ready), 32'd0);
      wait_cyc(e + 10);
      chk("same_stop_ready", 32'(div_ready), 32'd0);
      wait_cyc(e + 16);
      chk("same_running", 32'(running), 32'd0);
      chk("same_clk", 32'(dclk), 32'd1);
      chk("same_count", 32'(count), 32'd0);
      wait_cyc(e + 22);
      do_reset();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
